id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of the ALU. Captures the decoded
//  instruction and its rs/rt operands, resolves operand forwarding at capture
//  time, detects load-use hazards (stall + bubble), and honours branch flush.
//  Registered outputs drive alu.instruction/regA/regB and downstream EX/MEM.
// PARAMETERS
//  DW   32  datapath width (instruction and operand width)
//  RW   5   register index width
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high
//  in_valid       in   1   IF/ID holds a valid instruction
//  in_instr       in   DW  instruction from IF/ID
//  rf_rs_data     in   DW  register-file read of in_instr[25:21]
//  rf_rt_data     in   DW  register-file read of in_instr[20:16]
//  flush          in   1   branch/jump taken; discard in_instr
//  alu_result     in   DW  combinational ALU output for instruction held here
//  mem_wr_en/mem_rd/mem_data  in 1/RW/DW  MEM-stage pending write (incl. load data)
//  wb_wr_en/wb_rd/wb_data     in 1/RW/DW  WB-stage pending write
//  stall_out      out  1   combinational: IF/ID and PC must hold this cycle
//  ex_valid       out  1   held instruction is real (0 = bubble)
//  ex_instr       out  DW  to alu.instruction
//  ex_regA        out  DW  to alu.regA (rs operand)
//  ex_regB        out  DW  to alu.regB (rt operand)
//  ex_rd          out  RW  destination register index
//  ex_reg_write / ex_mem_read / ex_mem_write  out 1 each  control for later stages
// BEHAVIOUR
//  - Reset: every registered output 0 (ex_instr=0 is sll $0 NOP); stall_out 0.
//  - Latency 1 cycle: inputs sampled on rising clk, visible next cycle.
//  - Decode of in_instr: opcode 0x00 -> dest rd=[15:11], reg_write=1 except
//    funct 0x08 (jr); opcodes 08,09,0A,0B,0C,0D,0E,0F,23 -> dest rt=[20:16],
//    reg_write=1; 0x23 also mem_read=1; 0x2B -> mem_write=1, no dest; all
//    others (beq 04, bne 05, j/jal, unknown) -> no write, dest 0. Dest 0 forces
//    reg_write=0.
//  - uses_rt = opcode in {00,04,05,2B}; rs is always treated as used.
//  - Forwarding per operand (rs, rt), index r != 0, priority high->low:
//    1. ex_valid & ex_reg_write & !ex_mem_read & ex_rd==r -> alu_result
//    2. mem_wr_en & mem_rd==r -> mem_data
//    3. wb_wr_en & wb_rd==r -> wb_data
//    4. else rf_*_data. r==0 always yields 0, never forwarded.
//  - Load-use: stall_out = in_valid & !flush & ex_valid & ex_mem_read &
//    (ex_rd==rs | (uses_rt & ex_rd==rt)); ex_rd!=0 is implied.
//  - Next-state priority: reset > flush > stall > capture.
//    flush: load bubble (all outputs 0), stall_out=0 regardless of hazard.
//    stall: load bubble; IF/ID holds, same instr re-presented next cycle and
//    captured then with load data via mem_* path.
//    capture: ex_valid=in_valid; if in_valid=0 load bubble.
//  - Bubble never stalls a following instruction (ex_valid=0 masks hazard).
//  - Stall lasts exactly 1 cycle per load-use pair; no back-to-back stall on
//    the same instruction.
//  - reset mid-stall: next cycle all outputs 0, stall_out 0 since ex_valid=0.
// TESTING
//  T1 reset: hold reset 2 cycles with in_valid=1 -> all ex_* 0, stall_out 0.
//  T2 capture: add $3,$1,$2 (0x00221820), rf 0xA/0x5, no pending writes ->
//     next cycle ex_regA=0xA, ex_regB=0x5, ex_rd=3, ex_reg_write=1.
//  T3 priority: rs=$1 with alu_result=0x11 (ex_rd=1), mem_rd=1 data 0x22,
//     wb_rd=1 data 0x33 -> ex_regA=0x11; drop EX match -> 0x22; drop MEM -> 0x33.
//  T4 load-use: lw $4,0($1) held, in add $5,$4,$4 -> stall_out=1, next cycle
//     bubble; re-presented add with mem_rd=4 data 0x77 -> ex_regA=ex_regB=0x77.
//  T5 $zero: add $0,$0,$0 with all forward sources rd=0 data 0xFF ->
//     ex_regA=ex_regB=0, ex_reg_write=0.
//  T6 flush during load-use hazard -> stall_out=0, bubble loaded, ex_valid=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: decodes the incoming instruction,
// resolves rs/rt forwarding at capture time, and inserts bubbles on load-use or flush.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_instr,
   input  logic [DW-1:0] rf_rs_data,
   input  logic [DW-1:0] rf_rt_data,
   input  logic          flush,
   input  logic [DW-1:0] alu_result,
   input  logic          mem_wr_en,
   input  logic [RW-1:0] mem_rd,
   input  logic [DW-1:0] mem_data,
   input  logic          wb_wr_en,
   input  logic [RW-1:0] wb_rd,
   input  logic [DW-1:0] wb_data,
   output logic          stall_out,
   output logic          ex_valid,
   output logic [DW-1:0] ex_instr,
   output logic [DW-1:0] ex_regA,
   output logic [DW-1:0] ex_regB,
   output logic [RW-1:0] ex_rd,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write
);

   logic          ex_valid_q, ex_valid_d;
   logic [DW-1:0] ex_instr_q, ex_instr_d;
   logic [DW-1:0] ex_rega_q, ex_rega_d;
   logic [DW-1:0] ex_regb_q, ex_regb_d;
   logic [RW-1:0] ex_rd_q, ex_rd_d;
   logic          ex_reg_write_q, ex_reg_write_d;
   logic          ex_mem_read_q, ex_mem_read_d;
   logic          ex_mem_write_q, ex_mem_write_d;

   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic [RW-1:0] rs_idx, rt_idx, rd_idx;
   logic [RW-1:0] dec_rd;
   logic          dec_reg_write, dec_mem_read, dec_mem_write;
   logic          uses_rt;
   logic          hazard;
   logic          load;

   // An EX-stage load cannot forward through alu_result: its data only exists in MEM.
   function automatic logic [DW-1:0] fwd(input logic [RW-1:0] r, input logic [DW-1:0] rf);
      if (r == '0)
         return '0;
      else if (ex_valid_q && ex_reg_write_q && !ex_mem_read_q && ex_rd_q == r)
         return alu_result;
      else if (mem_wr_en && mem_rd == r)
         return mem_data;
      else if (wb_wr_en && wb_rd == r)
         return wb_data;
      else
         return rf;
   endfunction

   always_comb begin
      opcode        = in_instr[31:26];
      funct         = in_instr[5:0];
      rs_idx        = RW'(in_instr[25:21]);
      rt_idx        = RW'(in_instr[20:16]);
      rd_idx        = RW'(in_instr[15:11]);
      dec_rd        = '0;
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      case (opcode)
         6'h00: begin
            dec_rd        = rd_idx;
            dec_reg_write = (funct != 6'h08);
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
            dec_rd        = rt_idx;
            dec_reg_write = 1'b1;
            dec_mem_read  = (opcode == 6'h23);
         end
         6'h2B:   dec_mem_write = 1'b1;
         default: ;
      endcase
      if (dec_rd == '0)
         dec_reg_write = 1'b0;
      uses_rt = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h05) || (opcode == 6'h2B);

      hazard = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
               ((ex_rd_q == rs_idx) || (uses_rt && ex_rd_q == rt_idx));
      stall_out = in_valid && !flush && hazard;

      // Flush, stall and an empty IF/ID slot all load the same all-zero bubble.
      load           = in_valid && !flush && !stall_out;
      ex_valid_d     = load;
      ex_instr_d     = load ? in_instr : '0;
      ex_rega_d      = load ? fwd(rs_idx, rf_rs_data) : '0;
      ex_regb_d      = load ? fwd(rt_idx, rf_rt_data) : '0;
      ex_rd_d        = load ? dec_rd : '0;
      ex_reg_write_d = load && dec_reg_write;
      ex_mem_read_d  = load && dec_mem_read;
      ex_mem_write_d = load && dec_mem_write;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q     <= 1'b0;
         ex_instr_q     <= '0;
         ex_rega_q      <= '0;
         ex_regb_q      <= '0;
         ex_rd_q        <= '0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_mem_write_q <= 1'b0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_instr_q     <= ex_instr_d;
         ex_rega_q      <= ex_rega_d;
         ex_regb_q      <= ex_regb_d;
         ex_rd_q        <= ex_rd_d;
         ex_reg_write_q <= ex_reg_write_d;
         ex_mem_read_q  <= ex_mem_read_d;
         ex_mem_write_q <= ex_mem_write_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_instr     = ex_instr_q;
   assign ex_regA      = ex_rega_q;
   assign ex_regB      = ex_regb_q;
   assign ex_rd        = ex_rd_q;
   assign ex_reg_write = ex_reg_write_q;
   assign ex_mem_read  = ex_mem_read_q;
   assign ex_mem_write = ex_mem_write_q;

endmodule
